// File: rtl/neuro_nav_pkg.sv
// Shared types and helpers for the odometry spike encoder.
package neuro_nav_pkg;

  // Spike direction as seen by the position peripheral.
  typedef enum logic [1:0] {
    DIR_E = 2'd0,
    DIR_N = 2'd1,
    DIR_W = 2'd2,
    DIR_S = 2'd3
  } dir_e;

  // Bus write sequencer states.
  typedef enum logic [1:0] {
    StIdle,
    StWrSpike,
    StWrEn,
    StWrDis
  } state_e;

  // bus_write_n encodings.
  localparam logic [1:0] WR_WORD = 2'b10;
  localparam logic [1:0] WR_IDLE = 2'b11;

  // Spike packet register layout: {14'b0, dir, weight}.
  function automatic logic [31:0] pack_spike(input dir_e dir, input logic [15:0] weight);
    return {14'b0, dir, weight};
  endfunction

endpackage

// File: rtl/lif_axis_acc.sv
// One axis of leaky integrate-and-fire accumulation: leak, add sample, subtract on fire,
// saturate. The saturated output exists only when NEURO_SPIKE_CNT_EN is defined.
module lif_axis_acc #(
  parameter int unsigned ACC_W      = 20,
  parameter int unsigned THRESHOLD  = 256,
  parameter int unsigned LEAK_SHIFT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    leak_tick,
  input  logic                    sample_en,
  input  logic signed [15:0]      delta,
  input  logic                    fire,
  output logic signed [ACC_W-1:0] acc,
  output logic                    eligible
`ifdef NEURO_SPIKE_CNT_EN
  ,
  output logic                    saturated
`endif
);

  // Two guard bits: |acc| + |delta| + THRESHOLD never exceeds 2^(ACC_W+1).
  localparam int unsigned SumW = ACC_W + 2;
  localparam logic signed [SumW-1:0] AccMax = {3'b000, {(ACC_W - 1){1'b1}}};
  localparam logic signed [SumW-1:0] AccMin = -AccMax;
  localparam logic signed [SumW-1:0] ThrExt = SumW'(THRESHOLD);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [SumW-1:0]  acc_ext, abs_ext, leak_mag, leak_term, delta_term, fire_term, sum;
  logic                    neg, over, under;

  // Next accumulator value; every term derives from the registered acc.
  always_comb begin
    neg        = acc_q[ACC_W-1];
    acc_ext    = {{2{acc_q[ACC_W-1]}}, acc_q};
    abs_ext    = neg ? -acc_ext : acc_ext;
    leak_mag   = abs_ext >>> LEAK_SHIFT;
    leak_term  = '0;
    delta_term = '0;
    fire_term  = '0;
    if (leak_tick) leak_term = neg ? -leak_mag : leak_mag;
    if (sample_en) delta_term = {{(SumW - 16){delta[15]}}, delta};
    if (fire)      fire_term = neg ? -ThrExt : ThrExt;
    sum   = acc_ext - leak_term + delta_term - fire_term;
    over  = sum > AccMax;
    under = sum < AccMin;
    if (over)       acc_d = AccMax[ACC_W-1:0];
    else if (under) acc_d = AccMin[ACC_W-1:0];
    else            acc_d = sum[ACC_W-1:0];
  end

  // Accumulator state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc      = acc_q;
  assign eligible = abs_ext >= ThrExt;
`ifdef NEURO_SPIKE_CNT_EN
  assign saturated = over | under;
`endif

endmodule

// File: rtl/neuro_spike_encoder.sv
// Odometry-to-spike bus initiator: integrates dx/dy per axis and, on each threshold crossing,
// writes spike packet, enable, disable into the position peripheral.
// Optional: define NEURO_SPIKE_CNT_EN to add spike_count and sat_flag outputs.
module neuro_spike_encoder
  import neuro_nav_pkg::*;
#(
  parameter int unsigned ACC_W       = 20,
  parameter int unsigned THRESHOLD   = 256,
  parameter int unsigned LEAK_SHIFT  = 4,
  parameter int unsigned LEAK_PERIOD = 1024,
  parameter logic [5:0]  SPIKE_ADDR  = 6'h0,
  parameter logic [5:0]  CTRL_ADDR   = 6'h4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_dx,
  input  logic [15:0] s_dy,
  output logic [5:0]  bus_address,
  output logic [31:0] bus_wdata,
  output logic [1:0]  bus_write_n,
  input  logic        bus_ready,
  output logic        busy
`ifdef NEURO_SPIKE_CNT_EN
  ,
  output logic [15:0] spike_count,
  output logic        sat_flag
`endif
);

  localparam int unsigned LeakCntW = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
  localparam logic [LeakCntW-1:0] LeakLast =
      (LEAK_PERIOD == 0) ? '0 : LeakCntW'(LEAK_PERIOD - 1);
  localparam logic [15:0] Weight = 16'(THRESHOLD);

  state_e                  state_q;
  logic                    rr_q, rr_d;  // 0: X has priority on a tie, 1: Y
  logic [LeakCntW-1:0]     leak_cnt_q;
  logic                    leak_tick, sample_take;
  logic                    elig_x, elig_y, fire_x, fire_y;
  logic signed [ACC_W-1:0] acc_x, acc_y;
  dir_e                    fire_dir;

  // Accumulators saturate instead of stalling the source.
  assign s_ready     = 1'b1;
  assign sample_take = s_valid & s_ready;
  assign leak_tick   = (LEAK_PERIOD != 0) && (leak_cnt_q == LeakLast);
  assign busy        = (state_q != StIdle);

`ifdef NEURO_SPIKE_CNT_EN
  logic sat_x, sat_y;
`endif

  lif_axis_acc #(
    .ACC_W      (ACC_W),
    .THRESHOLD  (THRESHOLD),
    .LEAK_SHIFT (LEAK_SHIFT)
  ) u_acc_x (
    .clk       (clk),
    .rst       (rst),
    .leak_tick (leak_tick),
    .sample_en (sample_take),
    .delta     (s_dx),
    .fire      (fire_x),
    .acc       (acc_x),
    .eligible  (elig_x)
`ifdef NEURO_SPIKE_CNT_EN
    ,
    .saturated (sat_x)
`endif
  );

  lif_axis_acc #(
    .ACC_W      (ACC_W),
    .THRESHOLD  (THRESHOLD),
    .LEAK_SHIFT (LEAK_SHIFT)
  ) u_acc_y (
    .clk       (clk),
    .rst       (rst),
    .leak_tick (leak_tick),
    .sample_en (sample_take),
    .delta     (s_dy),
    .fire      (fire_y),
    .acc       (acc_y),
    .eligible  (elig_y)
`ifdef NEURO_SPIKE_CNT_EN
    ,
    .saturated (sat_y)
`endif
  );

  // Fire arbitration, only while idle; round-robin on a tie.
  always_comb begin
    fire_x   = 1'b0;
    fire_y   = 1'b0;
    rr_d     = rr_q;
    fire_dir = DIR_E;
    if (state_q == StIdle) begin
      if (elig_x && elig_y) begin
        fire_x = ~rr_q;
        fire_y = rr_q;
        rr_d   = ~rr_q;
      end else if (elig_x) begin
        fire_x = 1'b1;
        rr_d   = 1'b1;
      end else if (elig_y) begin
        fire_y = 1'b1;
        rr_d   = 1'b0;
      end
    end
    if (fire_x)      fire_dir = acc_x[ACC_W-1] ? DIR_W : DIR_E;
    else if (fire_y) fire_dir = acc_y[ACC_W-1] ? DIR_S : DIR_N;
  end

  // Leak period counter; the tick is the wrap cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   leak_cnt_q <= '0;
    else if (LEAK_PERIOD == 0) leak_cnt_q <= '0;
    else if (leak_tick)        leak_cnt_q <= '0;
    else                       leak_cnt_q <= leak_cnt_q + 1'b1;
  end

  // Write sequencer with registered bus outputs held until bus_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_q        <= 1'b0;
      bus_address <= '0;
      bus_wdata   <= '0;
      bus_write_n <= WR_IDLE;
    end else begin
      unique case (state_q)
        StIdle: begin
          rr_q <= rr_d;
          if (fire_x || fire_y) begin
            state_q     <= StWrSpike;
            bus_address <= SPIKE_ADDR;
            bus_wdata   <= pack_spike(fire_dir, Weight);
            bus_write_n <= WR_WORD;
          end
        end
        StWrSpike: if (bus_ready) begin
          state_q     <= StWrEn;
          bus_address <= CTRL_ADDR;
          bus_wdata   <= 32'h1;
        end
        StWrEn: if (bus_ready) begin
          state_q   <= StWrDis;
          bus_wdata <= 32'h0;
        end
        StWrDis: if (bus_ready) begin
          state_q     <= StIdle;
          bus_address <= '0;
          bus_wdata   <= '0;
          bus_write_n <= WR_IDLE;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef NEURO_SPIKE_CNT_EN
  logic [15:0] spike_count_q;
  logic        sat_flag_q;

  // Completed-sequence counter and sticky saturation flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spike_count_q <= '0;
      sat_flag_q    <= 1'b0;
    end else begin
      if (state_q == StWrDis && bus_ready) spike_count_q <= spike_count_q + 16'd1;
      if (sat_x || sat_y) sat_flag_q <= 1'b1;
    end
  end

  assign spike_count = spike_count_q;
  assign sat_flag    = sat_flag_q;
`endif

endmodule

// File: tb/tb_neuro_spike_encoder.sv
// Self-checking bench for neuro_spike_encoder: a scoreboard queue of expected bus writes is
// filled as samples are driven and drained by a write monitor; scenario tasks check the rest.
`timescale 1ns/1ps
module tb_neuro_spike_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_dx = '0;
  logic [15:0] s_dy = '0;
  logic [5:0]  bus_address;
  logic [31:0] bus_wdata;
  logic [1:0]  bus_write_n;
  logic        bus_ready = 1'b1;
  logic        busy;
`ifdef NEURO_SPIKE_CNT_EN
  logic [15:0] spike_count;
  logic        sat_flag;
`endif

  always #5 clk = ~clk;

  neuro_spike_encoder dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_dx        (s_dx),
    .s_dy        (s_dy),
    .bus_address (bus_address),
    .bus_wdata   (bus_wdata),
    .bus_write_n (bus_write_n),
    .bus_ready   (bus_ready),
    .busy        (busy)
`ifdef NEURO_SPIKE_CNT_EN
    ,
    .spike_count (spike_count),
    .sat_flag    (sat_flag)
`endif
  );

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  hs_cyc[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  bit  sb_en    = 1'b1;

  always @(posedge clk) cyc++;

  // Write monitor: every accepted write must match the head of the scoreboard.
  always @(negedge clk) begin
    wr_t e;
    if (!rst && sb_en && bus_write_n == 2'b10 && bus_ready) begin
      n_checks++;
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL bus_write: unexpected write addr=%h data=%h", bus_address, bus_wdata);
      end else begin
        e = exp_q.pop_front();
        if (bus_address !== e.addr || bus_wdata !== e.data) begin
          n_fail++;
          $display("FAIL bus_write: got addr=%h data=%h, expected addr=%h data=%h",
                   bus_address, bus_wdata, e.addr, e.data);
        end
      end
    end
  end

  // Expected three-write sequence for one spike of direction dir.
  function automatic void push_seq(input logic [1:0] dir);
    exp_q.push_back({6'h0, 14'b0, dir, 16'h0100});
    exp_q.push_back({6'h4, 32'h1});
    exp_q.push_back({6'h4, 32'h0});
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    bus_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    hs_cyc.delete();
    rst = 1'b0;
  endtask

  // Called at posedge+1; the sample is accepted on the next edge.
  task automatic send(input logic [15:0] dx, input logic [15:0] dy);
    s_dx = dx;
    s_dy = dy;
    s_valid = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    n_checks++;
    if (exp_q.size() != 0 || busy) begin
      n_fail++;
      $display("FAIL wait_done: timeout, %0d writes outstanding, busy=%b, expected 0 and 0",
               exp_q.size(), busy);
    end
  endtask

  task automatic test_reset();
    int t = 0;
    do_reset();
    n_checks++;
    if (bus_write_n !== 2'b11 || bus_address !== 6'h0 || bus_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_bus: write_n=%b addr=%h data=%h, expected 11/00/00000000",
               bus_write_n, bus_address, bus_wdata);
    end
    n_checks++;
    if (busy !== 1'b0 || s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ctl: busy=%b s_ready=%b, expected 0/1", busy, s_ready);
    end
    n_checks++;
    if (dut.acc_x !== 20'sd0 || dut.acc_y !== 20'sd0) begin
      n_fail++;
      $display("FAIL reset_acc: acc_x=%0d acc_y=%0d, expected 0/0", dut.acc_x, dut.acc_y);
    end
    // Start a sequence and park it in the enable write.
    push_seq(2'd0);
    repeat (3) send(16'd100, 16'd0);
    while (!(bus_write_n == 2'b10 && bus_address == 6'h4 && bus_wdata == 32'h1) && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    bus_ready = 1'b0;
    n_checks++;
    if (t >= 20) begin
      n_fail++;
      $display("FAIL reset_reach_en: enable write not presented within 20 cycles");
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus_write_n !== 2'b11 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abort: write_n=%b busy=%b, expected 11/0", bus_write_n, busy);
    end
    exp_q.delete();
    do_reset();
    push_seq(2'd0);
    repeat (3) send(16'd100, 16'd0);
    wait_done(30);
    n_checks++;
    if (dut.acc_x !== 20'sd44) begin
      n_fail++;
      $display("FAIL reset_restart_acc: acc_x=%0d, expected 44", dut.acc_x);
    end
  endtask

  task automatic test_pos_x();
    do_reset();
    push_seq(2'd0);
    repeat (3) send(16'd100, 16'd0);
    wait_done(30);
    n_checks++;
    if (dut.acc_x !== 20'sd44) begin
      n_fail++;
      $display("FAIL pos_x_acc: acc_x=%0d, expected 44", dut.acc_x);
    end
    n_checks++;
    if (hs_cyc.size() != 3) begin
      n_fail++;
      $display("FAIL pos_x_count: %0d writes, expected 3", hs_cyc.size());
    end else if (hs_cyc[1] != hs_cyc[0] + 1 || hs_cyc[2] != hs_cyc[1] + 1) begin
      n_fail++;
      $display("FAIL pos_x_spacing: write cycles %0d %0d %0d, expected consecutive",
               hs_cyc[0], hs_cyc[1], hs_cyc[2]);
    end
`ifdef NEURO_SPIKE_CNT_EN
    n_checks++;
    if (spike_count !== 16'd1) begin
      n_fail++;
      $display("FAIL spike_count: got %0d, expected 1", spike_count);
    end
`endif
  endtask

  task automatic test_neg_y();
    do_reset();
    push_seq(2'd3);
    send(16'd0, -16'sd300);
    wait_done(30);
    n_checks++;
    if (dut.acc_y !== -20'sd44 || dut.acc_x !== 20'sd0) begin
      n_fail++;
      $display("FAIL neg_y_acc: acc_y=%0d acc_x=%0d, expected -44/0", dut.acc_y, dut.acc_x);
    end
  endtask

  task automatic test_both_axes();
    do_reset();
    push_seq(2'd0);
    push_seq(2'd1);
    send(16'd300, 16'd300);
    wait_done(40);
    n_checks++;
    if (dut.acc_x !== 20'sd44 || dut.acc_y !== 20'sd44) begin
      n_fail++;
      $display("FAIL both_acc: acc_x=%0d acc_y=%0d, expected 44/44", dut.acc_x, dut.acc_y);
    end
    n_checks++;
    if (hs_cyc.size() != 6) begin
      n_fail++;
      $display("FAIL both_count: %0d writes, expected 6", hs_cyc.size());
    end
  endtask

  task automatic test_back_pressure();
    int t = 0;
    do_reset();
    push_seq(2'd0);
    bus_ready = 1'b0;
    send(16'd300, 16'd0);
    while (bus_write_n !== 2'b10 && t < 10) begin
      @(posedge clk);
      #1;
      t++;
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (bus_write_n !== 2'b10 || bus_address !== 6'h0 || bus_wdata !== 32'h0000_0100) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: write_n=%b addr=%h data=%h, expected 10/00/00000100",
                 i, bus_write_n, bus_address, bus_wdata);
      end
      @(posedge clk);
      #1;
    end
    bus_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus_address !== 6'h4 || bus_wdata !== 32'h1 || bus_write_n !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_advance: write_n=%b addr=%h data=%h, expected 10/04/00000001",
               bus_write_n, bus_address, bus_wdata);
    end
    wait_done(20);
  endtask

  task automatic test_leak_sat();
    bit wrapped = 1'b0;
    do_reset();
    repeat (2) send(16'd100, 16'd0);
    repeat (900) @(posedge clk);
    #1;
    n_checks++;
    if (dut.acc_x !== 20'sd200) begin
      n_fail++;
      $display("FAIL leak_before: acc_x=%0d, expected 200", dut.acc_x);
    end
    repeat (200) @(posedge clk);
    #1;
    n_checks++;
    if (dut.acc_x !== 20'sd188) begin
      n_fail++;
      $display("FAIL leak_after: acc_x=%0d, expected 188", dut.acc_x);
    end
    // Saturation: spikes still fire, so stop scoreboarding the backlog.
    sb_en = 1'b0;
    s_dx = 16'sd32767;
    s_dy = 16'd0;
    s_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (dut.acc_x[19]) wrapped = 1'b1;
    end
    n_checks++;
    if (dut.acc_x !== 20'sd524287) begin
      n_fail++;
      $display("FAIL sat_value: acc_x=%0d, expected 524287", dut.acc_x);
    end
    n_checks++;
    if (wrapped) begin
      n_fail++;
      $display("FAIL sat_wrap: acc_x went negative, expected it to stay positive");
    end
    s_valid = 1'b0;
`ifdef NEURO_SPIKE_CNT_EN
    n_checks++;
    if (sat_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_flag: got %b, expected 1", sat_flag);
    end
`endif
    do_reset();
    sb_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_pos_x();
    test_neg_y();
    test_both_axes();
    test_back_pressure();
    test_leak_sat();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: %0d writes never seen, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
